// File: rtl/apb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_arbiter_pkg
// Shared types for the APB4 master-port arbiter.
//   apb_state_e : APB phase sequencer states (IDLE, SETUP, ACCESS).
//   apb_req_t   : one latched request (addr, write, wdata, strb, prot).
// The struct is sized to the widest supported configuration. The arbiter
// zero-extends narrower requests into it and slices them back out for PADDR,
// PWDATA and PSTRB.
// -----------------------------------------------------------------------------
package apb_arbiter_pkg;

  localparam int APB_ADDR_MAX = 32;
  localparam int APB_DATA_MAX = 64;
  localparam int APB_STRB_MAX = APB_DATA_MAX / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_MAX-1:0] addr;
    logic                    write;
    logic [APB_DATA_MAX-1:0] wdata;
    logic [APB_STRB_MAX-1:0] strb;
    logic [2:0]              prot;
  } apb_req_t;

endpackage

// File: rtl/apb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at last+1 and wraps
// modulo NREQ. The first set bit of req wins.
//   req   in  NREQ          : request vector
//   last  in  $clog2(NREQ)  : index of the previous winner
//   grant out NREQ          : one-hot winner (all zero when req == 0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
// Shares one APB4 master port among NREQ requesters. Requesters are selected
// round-robin. The block sequences SETUP and ACCESS and returns read data and
// error status. A PREADY stall is bounded by TIMEOUT cycles, and 0 disables
// the bound.
// Ports:
//   HCLK, HRESET         : clock, synchronous active-high reset
//   req_valid/addr/write/wdata/strb/prot : per-requester request (flattened)
//   req_ready            : one-hot pulse, request accepted
//   rsp_valid            : one-hot pulse, transfer complete
//   rsp_rdata, rsp_err   : response payload, valid with rsp_valid
//   PSEL..PWDATA         : APB4 master outputs (registered)
//   PRDATA, PREADY, PSLVERR : APB4 slave response
// -----------------------------------------------------------------------------
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*PADDR_SIZE-1:0]     req_addr,
  input  logic [NREQ-1:0]                req_write,
  input  logic [NREQ*PDATA_SIZE-1:0]     req_wdata,
  input  logic [NREQ*(PDATA_SIZE/8)-1:0] req_strb,
  input  logic [NREQ*3-1:0]              req_prot,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [PDATA_SIZE-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [2:0]                     PPROT,
  output logic [PDATA_SIZE/8-1:0]        PSTRB,
  output logic [PADDR_SIZE-1:0]          PADDR,
  output logic [PDATA_SIZE-1:0]          PWDATA,
  input  logic [PDATA_SIZE-1:0]          PRDATA,
  input  logic                           PREADY,
  input  logic                           PSLVERR
);

  localparam int STRB_W = PDATA_SIZE / 8;
  localparam int IDX_W  = $clog2(NREQ);
  localparam int TMO_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_SAT   = '1;

  apb_state_e              state_q;
  logic [IDX_W-1:0]        last_q;
  logic [NREQ-1:0]         gnt_q;
  apb_req_t                req_q;
  logic                    psel_q;
  logic                    penable_q;
  logic [NREQ-1:0]         req_ready_q;
  logic [NREQ-1:0]         rsp_valid_q;
  logic [PDATA_SIZE-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic [TMO_W-1:0]        tmo_q;

  logic [NREQ-1:0]         win_oh_d;
  logic [IDX_W-1:0]        win_idx_d;
  apb_req_t                win_req_d;
  logic                    win_any;
  logic                    tmo_hit;
  logic                    xfer_done;
  logic                    arb_en;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (win_oh_d)
  );

  assign win_any = |win_oh_d;

  // Gather the winner's fields. PSTRB is forced to 0 for reads here, so the
  // output register already holds the value that APB4 requires.
  always_comb begin
    win_req_d = '0;
    win_idx_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh_d[i]) begin
        win_idx_d       = IDX_W'(i);
        win_req_d.addr  = APB_ADDR_MAX'(req_addr[i*PADDR_SIZE +: PADDR_SIZE]);
        win_req_d.write = req_write[i];
        win_req_d.wdata = APB_DATA_MAX'(req_wdata[i*PDATA_SIZE +: PDATA_SIZE]);
        win_req_d.strb  = req_write[i] ? APB_STRB_MAX'(req_strb[i*STRB_W +: STRB_W]) : '0;
        win_req_d.prot  = req_prot[i*3 +: 3];
      end
    end
  end

  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LIMIT);
  assign xfer_done = (state_q == ACCESS) && (PREADY || tmo_hit);
  // Arbitration also runs in the completing ACCESS cycle. This gives
  // back-to-back transfers with no IDLE gap.
  assign arb_en    = (state_q == IDLE) || xfer_done;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NREQ - 1);
      gnt_q       <= '0;
      req_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          tmo_q     <= '0;
        end
        ACCESS: begin
          if (xfer_done) begin
            rsp_valid_q <= gnt_q;
            // PRDATA is taken only when PREADY is high. A timeout returns 0.
            rsp_rdata_q <= (PREADY && !req_q.write) ? PRDATA : '0;
            rsp_err_q   <= PREADY ? PSLVERR : 1'b1;
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
          end else if (tmo_q != TMO_SAT) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase

      // A grant overrides the IDLE fallback above.
      if (arb_en && win_any) begin
        state_q     <= SETUP;
        psel_q      <= 1'b1;
        penable_q   <= 1'b0;
        req_q       <= win_req_d;
        last_q      <= win_idx_d;
        gnt_q       <= win_oh_d;
        req_ready_q <= win_oh_d;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = req_q.write;
  assign PPROT     = req_q.prot;
  assign PADDR     = req_q.addr[PADDR_SIZE-1:0];
  assign PWDATA    = req_q.wdata[PDATA_SIZE-1:0];
  assign PSTRB     = req_q.strb[STRB_W-1:0];

  // These are the struct bits above the configured widths. They are always zero.
  logic unused_hi;
  assign unused_hi = ^(req_q.addr >> PADDR_SIZE) ^ ^(req_q.wdata >> PDATA_SIZE)
                   ^ ^(req_q.strb >> STRB_W);

endmodule
